// File: rtl/adpll_lock_ctrl_if.sv
// Signal bundle between the ADPLL loop controller and its environment (PFD flags in, DCO word out).
// ADPLL_LOCK_CTRL_FREEZE_EN adds the freeze input to the bundle.
interface adpll_lock_ctrl_if #(
  parameter int CODE_W = 10
);
  logic              en;
  logic              flagu;
  logic              flagd;
`ifdef ADPLL_LOCK_CTRL_FREEZE_EN
  logic              freeze;
`endif
  logic [CODE_W-1:0] dco_code;
  logic              lock;
  logic [1:0]        state;

`ifdef ADPLL_LOCK_CTRL_FREEZE_EN
  modport master (output en, flagu, flagd, freeze, input dco_code, lock, state);
  modport slave  (input en, flagu, flagd, freeze, output dco_code, lock, state);
`else
  modport master (output en, flagu, flagd, input dco_code, lock, state);
  modport slave  (input en, flagu, flagd, output dco_code, lock, state);
`endif
endinterface

// File: rtl/adpll_lock_ctrl.sv
// ADPLL loop controller: synchronises PFD flags, runs binary-search acquisition then +/-1 tracking.
// Optional ADPLL_LOCK_CTRL_FREEZE_EN: freeze input holds code and counters while LOCKED.
module adpll_lock_ctrl #(
  parameter int CODE_W     = 10,
  parameter int DIV_LOG2   = 2,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  adpll_lock_ctrl_if.slave  bus
);

  localparam int TW = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_RUN + 1);
  localparam logic [TW-1:0]     TICK_MAX  = TW'((1 << DIV_LOG2) - 1);
  localparam logic [CODE_W-1:0] CODE_MID  = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0] CODE_MAX  = '1;
  localparam logic [CODE_W-1:0] STEP_INIT = CODE_W'(1) << (CODE_W - 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] step_q, step_d;
  logic              lock_q, lock_d;
  logic [RW-1:0]     rev_cnt_q, rev_cnt_d;
  logic [UW-1:0]     run_cnt_q, run_cnt_d;
  logic              last_up_q, last_up_d;
  logic              last_valid_q, last_valid_d;
  logic              fu_s1_q, fu_s1_d, fu_s2_q, fu_s2_d;
  logic              fd_s1_q, fd_s1_d, fd_s2_q, fd_s2_d;

  logic              tick;
  logic              frz;
  logic              dir_up, dir_dn, step_any, is_rev;
  logic [CODE_W:0]   sum_w;
  logic [CODE_W-1:0] code_up, code_dn, code_step;
  logic [RW-1:0]     rev_inc;
  logic [UW-1:0]     run_inc;

`ifdef ADPLL_LOCK_CTRL_FREEZE_EN
  assign frz = bus.freeze;
`else
  assign frz = 1'b0;
`endif

  assign tick     = (tick_cnt_q == TICK_MAX);
  assign dir_up   = fu_s2_q & ~fd_s2_q;
  assign dir_dn   = fd_s2_q & ~fu_s2_q;
  assign step_any = dir_up | dir_dn;
  // A reversal needs a remembered previous direction; the first step after SEARCH start has none.
  assign is_rev   = step_any & last_valid_q & (dir_up != last_up_q);
  assign rev_inc  = rev_cnt_q + 1'b1;
  assign run_inc  = run_cnt_q + 1'b1;

  // Saturating add/subtract of the current step; the carry bit catches overflow past CODE_MAX.
  assign sum_w     = {1'b0, code_q} + {1'b0, step_q};
  assign code_up   = sum_w[CODE_W] ? CODE_MAX : sum_w[CODE_W-1:0];
  assign code_dn   = (step_q > code_q) ? '0 : (code_q - step_q);
  assign code_step = dir_up ? code_up : (dir_dn ? code_dn : code_q);

  always_comb begin
    tick_cnt_d   = tick ? '0 : (tick_cnt_q + 1'b1);
    fu_s1_d      = bus.flagu;
    fu_s2_d      = fu_s1_q;
    fd_s1_d      = bus.flagd;
    fd_s2_d      = fd_s1_q;
    state_d      = state_q;
    code_d       = code_q;
    step_d       = step_q;
    lock_d       = lock_q;
    rev_cnt_d    = rev_cnt_q;
    run_cnt_d    = run_cnt_q;
    last_up_d    = last_up_q;
    last_valid_d = last_valid_q;

    case (state_q)
      ST_IDLE: begin
        lock_d = 1'b0;
        if (tick && bus.en) begin
          state_d      = ST_SEARCH;
          code_d       = CODE_MID;
          step_d       = STEP_INIT;
          rev_cnt_d    = '0;
          run_cnt_d    = '0;
          last_valid_d = 1'b0;
        end
      end

      ST_SEARCH: begin
        if (tick) begin
          code_d = code_step;
          step_d = step_q >> 1;
          if (step_any) begin
            last_up_d    = dir_up;
            last_valid_d = 1'b1;
          end
          if (step_q == CODE_W'(1)) begin
            state_d   = ST_TRACK;
            step_d    = CODE_W'(1);
            rev_cnt_d = '0;
          end
        end
      end

      ST_TRACK: begin
        if (tick) begin
          code_d = code_step;
          if (step_any) begin
            last_up_d    = dir_up;
            last_valid_d = 1'b1;
            if (is_rev) begin
              rev_cnt_d = rev_inc;
              if (rev_inc == RW'(LOCK_CNT)) begin
                state_d   = ST_LOCKED;
                lock_d    = 1'b1;
                rev_cnt_d = '0;
                run_cnt_d = '0;
              end
            end else begin
              rev_cnt_d = '0;
            end
          end
        end
      end

      ST_LOCKED: begin
        if (tick && !frz) begin
          code_d = code_step;
          if (step_any) begin
            last_up_d    = dir_up;
            last_valid_d = 1'b1;
            if (is_rev) begin
              run_cnt_d = '0;
            end else begin
              run_cnt_d = run_inc;
              if (run_inc == UW'(UNLOCK_RUN)) begin
                state_d   = ST_TRACK;
                lock_d    = 1'b0;
                rev_cnt_d = '0;
                run_cnt_d = '0;
              end
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Dropping en wins over everything on any clk, not just ticks; the code word is frozen.
    if (!bus.en) begin
      state_d = ST_IDLE;
      lock_d  = 1'b0;
      code_d  = code_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      code_q       <= CODE_MID;
      step_q       <= '0;
      lock_q       <= 1'b0;
      rev_cnt_q    <= '0;
      run_cnt_q    <= '0;
      last_up_q    <= 1'b0;
      last_valid_q <= 1'b0;
      fu_s1_q      <= 1'b0;
      fu_s2_q      <= 1'b0;
      fd_s1_q      <= 1'b0;
      fd_s2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      code_q       <= code_d;
      step_q       <= step_d;
      lock_q       <= lock_d;
      rev_cnt_q    <= rev_cnt_d;
      run_cnt_q    <= run_cnt_d;
      last_up_q    <= last_up_d;
      last_valid_q <= last_valid_d;
      fu_s1_q      <= fu_s1_d;
      fu_s2_q      <= fu_s2_d;
      fd_s1_q      <= fd_s1_d;
      fd_s2_q      <= fd_s2_d;
    end
  end

  assign bus.dco_code = code_q;
  assign bus.lock     = lock_q;
  assign bus.state    = state_q;

endmodule
